// File: rtl/traceback_engine_pkg.sv
// rtl/traceback_engine_pkg.sv - shared defaults, FSM encoding and sizing helper for the traceback engine
package traceback_engine_pkg;

    localparam int DEF_WD_STATE = 6;
    localparam int DEF_WD_COL   = 6;
    localparam int DEF_TB_DEPTH = 32;
    localparam int DEF_DEC_LEN  = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        TRACE  = 2'd1,
        DECODE = 2'd2,
        DRAIN  = 2'd3
    } tbState_e;

    // Bits needed to hold the values 0..n-1, never less than one.
    function automatic int cntWidth(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/traceback_engine_if.sv
// rtl/traceback_engine_if.sv - start, survivor-memory and decoded-bit signals of the traceback engine
interface traceback_engine_if
    import traceback_engine_pkg::*;
#(
    parameter int WD_STATE = DEF_WD_STATE,
    parameter int WD_COL   = DEF_WD_COL
) ();

    logic                     Start;
    logic [WD_STATE-1:0]      InitState;
    logic [WD_COL-1:0]        StartCol;
    logic                     RdEn;
    logic [WD_COL-1:0]        RdAddr;
    logic [2**WD_STATE-1:0]   RdData;
    logic                     OutValid;
    logic                     OutReady;
    logic                     OutData;
    logic                     Busy;
    logic                     Done;

    modport master (
        output Start, InitState, StartCol, RdData, OutReady,
        input  RdEn, RdAddr, OutValid, OutData, Busy, Done
    );

    modport slave (
        input  Start, InitState, StartCol, RdData, OutReady,
        output RdEn, RdAddr, OutValid, OutData, Busy, Done
    );

endinterface

// File: rtl/traceback_engine_bit_lifo.sv
// rtl/traceback_engine_bit_lifo.sv - single-bit LIFO built as a shift register, top of stack at bit 0
module bit_lifo
    import traceback_engine_pkg::*;
#(
    parameter int DEPTH = DEF_DEC_LEN
) (
    input  logic Clock,
    input  logic Reset,
    input  logic push,
    input  logic pushBit,
    input  logic pop,
    output logic data,
    output logic empty
);

    localparam int CW = cntWidth(DEPTH + 1);

    logic [DEPTH-1:0] mem;
    logic [CW-1:0]    count;

    // Zeros shift in from the top on a pop, so an emptied stack reads back 0.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            mem   <= '0;
            count <= '0;
        end else if (push) begin
            mem   <= (mem << 1) | DEPTH'(pushBit);
            count <= count + 1'b1;
        end else if (pop) begin
            mem   <= mem >> 1;
            count <= count - 1'b1;
        end
    end

    assign data  = mem[0];
    assign empty = (count == '0);

endmodule

// File: rtl/traceback_engine.sv
// rtl/traceback_engine.sv - Viterbi survivor-memory traceback: walks back TB_DEPTH+DEC_LEN columns
// and emits the last DEC_LEN decisions in forward time order.
module traceback_engine
    import traceback_engine_pkg::*;
#(
    parameter int WD_STATE = DEF_WD_STATE,
    parameter int WD_COL   = DEF_WD_COL,
    parameter int TB_DEPTH = DEF_TB_DEPTH,
    parameter int DEC_LEN  = DEF_DEC_LEN
) (
    input  logic               Clock,
    input  logic               Reset,
    traceback_engine_if.slave  bus
);

    localparam int TOTAL = TB_DEPTH + DEC_LEN;
    localparam int CW    = cntWidth(TOTAL);
    localparam int PW    = cntWidth(DEC_LEN);

    tbState_e            fsm;
    logic [WD_STATE-1:0] stateReg;
    logic [WD_COL-1:0]   col;
    logic                rdEn;
    logic                rdValid;
    logic                outValid;
    logic [CW-1:0]       readCnt;
    logic [CW-1:0]       stepCnt;
    logic [PW-1:0]       popCnt;

    logic                survBit;
    logic [WD_STATE-1:0] nextState;
    logic                lifoPush;
    logic                lifoPop;
    logic                lifoData;
    logic                lifoEmpty;
    logic                lastAccept;

    assign survBit    = bus.RdData[stateReg];
    assign nextState  = {stateReg[WD_STATE-2:0], survBit};
    assign lifoPush   = rdValid && (fsm == DECODE);
    assign lifoPop    = outValid && bus.OutReady && !lifoEmpty;
    assign lastAccept = lifoPop && (popCnt == PW'(DEC_LEN - 1));

    // Reads run one cycle ahead of steps; rdValid marks the cycle RdData belongs to a step.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            fsm      <= IDLE;
            stateReg <= '0;
            col      <= '0;
            rdEn     <= 1'b0;
            rdValid  <= 1'b0;
            outValid <= 1'b0;
            readCnt  <= '0;
            stepCnt  <= '0;
            popCnt   <= '0;
        end else begin
            case (fsm)
                IDLE: begin
                    if (bus.Start) begin
                        fsm      <= TRACE;
                        stateReg <= bus.InitState;
                        col      <= bus.StartCol;
                        rdEn     <= 1'b1;
                        rdValid  <= 1'b0;
                        readCnt  <= '0;
                        stepCnt  <= '0;
                    end
                end
                TRACE, DECODE: begin
                    rdValid <= rdEn;
                    if (rdEn) begin
                        col     <= col - 1'b1;
                        readCnt <= readCnt + 1'b1;
                        if (readCnt == CW'(TOTAL - 1))
                            rdEn <= 1'b0;
                    end
                    if (rdValid) begin
                        stateReg <= nextState;
                        stepCnt  <= stepCnt + 1'b1;
                        if (fsm == TRACE && stepCnt == CW'(TB_DEPTH - 1))
                            fsm <= DECODE;
                        if (stepCnt == CW'(TOTAL - 1)) begin
                            fsm      <= DRAIN;
                            outValid <= 1'b1;
                            popCnt   <= '0;
                        end
                    end
                end
                DRAIN: begin
                    if (lifoPop) begin
                        popCnt <= popCnt + 1'b1;
                        if (lastAccept) begin
                            fsm      <= IDLE;
                            outValid <= 1'b0;
                        end
                    end
                end
                default: fsm <= IDLE;
            endcase
        end
    end

    bit_lifo #(
        .DEPTH (DEC_LEN)
    ) uLifo (
        .Clock   (Clock),
        .Reset   (Reset),
        .push    (lifoPush),
        .pushBit (stateReg[WD_STATE-1]),
        .pop     (lifoPop),
        .data    (lifoData),
        .empty   (lifoEmpty)
    );

    assign bus.RdEn     = rdEn;
    assign bus.RdAddr   = col;
    assign bus.OutValid = outValid;
    assign bus.OutData  = outValid & lifoData;
    assign bus.Busy     = (fsm != IDLE);
    assign bus.Done     = lastAccept;

endmodule

// File: tb/tb_traceback_engine.sv
// tb/tb_traceback_engine.sv - scoreboard bench for traceback_engine with a survivor-memory model
module tb_traceback_engine;

    logic Clock = 1'b0;
    logic Reset = 1'b0;
    always #5 Clock = ~Clock;

    traceback_engine_if #(.WD_STATE(6), .WD_COL(6)) bus ();

    traceback_engine #(
        .WD_STATE (6),
        .WD_COL   (6),
        .TB_DEPTH (32),
        .DEC_LEN  (32)
    ) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus)
    );

    int checks = 0;
    int passed = 0;

    logic [63:0] mem [64];
    bit          expQ[$];
    bit          gotQ[$];
    logic [5:0]  addrQ[$];
    int          cyc = 0;
    int          startCyc, firstRdCyc, firstValidCyc;
    bit          seenValid;
    int          doneCnt, doneIdx;

    always @(posedge Clock) cyc <= cyc + 1;

    always @(posedge Clock) if (bus.RdEn) bus.RdData <= mem[bus.RdAddr];

    always @(negedge Clock) begin
        if (Reset) begin
            if (bus.RdEn) begin
                if (addrQ.size() == 0) firstRdCyc = cyc;
                addrQ.push_back(bus.RdAddr);
            end
            if (bus.OutValid && !seenValid) begin
                seenValid = 1'b1;
                firstValidCyc = cyc;
            end
            if (bus.OutValid && bus.OutReady) gotQ.push_back(bus.OutData);
            if (bus.Done) begin
                doneCnt++;
                doneIdx = gotQ.size();
            end
        end
    end

    task automatic fill_mem(input int mode);
        for (int i = 0; i < 64; i++)
            mem[i] = (mode == 0) ? 64'd0 : (mode == 1) ? {64{1'b1}} : {$urandom, $urandom};
    endtask

    // Reference traceback computed straight from the algorithm, then Start pulsed for one cycle.
    task automatic start_run(input logic [5:0] init, input logic [5:0] col);
        logic [5:0] s;
        logic [5:0] c;
        bit tmp[$];
        expQ.delete(); gotQ.delete(); addrQ.delete();
        doneCnt = 0; doneIdx = -1; seenValid = 1'b0;
        s = init; c = col;
        for (int k = 1; k <= 64; k++) begin
            bit b;
            b = s[5];
            s = {s[4:0], mem[c][s]};
            c = c - 6'd1;
            if (k > 32) tmp.push_back(b);
        end
        for (int k = 31; k >= 0; k--) expQ.push_back(tmp[k]);
        bus.InitState = init;
        bus.StartCol  = col;
        bus.Start     = 1'b1;
        startCyc      = cyc;
        @(posedge Clock); #1;
        bus.Start = 1'b0;
    endtask

    task automatic wait_done(output bit timedOut);
        timedOut = 1'b1;
        for (int i = 0; i < 400; i++) begin
            @(posedge Clock); #1;
            if (doneCnt > 0) begin
                timedOut = 1'b0;
                break;
            end
        end
    endtask

    function automatic int firstDiff();
        if (gotQ.size() != expQ.size()) return -2;
        foreach (gotQ[i]) if (gotQ[i] !== expQ[i]) return i;
        return -1;
    endfunction

    task automatic test_reset();
        logic [5:0] outs;
        repeat (2) @(posedge Clock); #1;
        outs = {bus.RdEn, bus.OutValid, bus.OutData, bus.Busy, bus.Done, 1'b0};
        checks++; if (outs !== 6'd0) $display("FAIL reset_ctrl: got %b expected 000000", outs); else passed++;
        checks++; if (bus.RdAddr !== 6'd0) $display("FAIL reset_addr: got %0d expected 0", bus.RdAddr); else passed++;
        Reset = 1'b1;
        @(posedge Clock); #1;
    endtask

    task automatic test_all_zero();
        bit to;
        fill_mem(0);
        start_run(6'd0, 6'd0);
        wait_done(to);
        checks++; if (to) $display("FAIL zero_timeout: no Done within bound"); else passed++;
        checks++; if (firstValidCyc - startCyc !== 66) $display("FAIL zero_latency: got %0d expected 66", firstValidCyc - startCyc); else passed++;
        checks++; if (gotQ.size() !== 32) $display("FAIL zero_count: got %0d expected 32", gotQ.size()); else passed++;
        foreach (gotQ[i]) begin
            checks++; if (gotQ[i] !== 1'b0) $display("FAIL zero_bit%0d: got %b expected 0", i, gotQ[i]); else passed++;
        end
        checks++; if (doneCnt !== 1 || doneIdx !== 32) $display("FAIL zero_done: got count %0d at bit %0d expected 1 at 32", doneCnt, doneIdx); else passed++;
        checks++; if (bus.Busy !== 1'b0) $display("FAIL zero_busy: got %b expected 0", bus.Busy); else passed++;
    endtask

    task automatic test_all_ones();
        bit to;
        fill_mem(1);
        start_run(6'd0, 6'd17);
        wait_done(to);
        checks++; if (to || gotQ.size() !== 32) $display("FAIL ones_count: got %0d expected 32", gotQ.size()); else passed++;
        foreach (gotQ[i]) begin
            checks++; if (gotQ[i] !== 1'b1) $display("FAIL ones_bit%0d: got %b expected 1", i, gotQ[i]); else passed++;
        end
    endtask

    task automatic test_addr_seq();
        bit to;
        int d;
        fill_mem(2);
        start_run(6'd45, 6'd3);
        wait_done(to);
        checks++; if (firstRdCyc - startCyc !== 1) $display("FAIL addr_first_read: got cycle %0d expected 1", firstRdCyc - startCyc); else passed++;
        checks++; if (addrQ.size() !== 64) $display("FAIL addr_reads: got %0d expected 64", addrQ.size()); else passed++;
        foreach (addrQ[i]) begin
            logic [5:0] e;
            e = 6'd3 - 6'(i);
            checks++; if (addrQ[i] !== e) $display("FAIL addr_seq%0d: got %0d expected %0d", i, addrQ[i], e); else passed++;
        end
        d = firstDiff();
        checks++; if (to || d != -1) $display("FAIL addr_data: first bad index %0d expected -1", d); else passed++;
    endtask

    task automatic test_backpressure();
        bit to;
        bit heldData;
        int d, sz;
        fill_mem(2);
        start_run(6'd9, 6'd40);
        for (int i = 0; i < 200 && gotQ.size() < 10; i++) begin
            @(posedge Clock); #1;
        end
        bus.OutReady = 1'b0;
        heldData = bus.OutData;
        sz = gotQ.size();
        for (int i = 0; i < 5; i++) begin
            @(negedge Clock);
            checks++; if (bus.OutValid !== 1'b1 || bus.OutData !== heldData)
                $display("FAIL bp_hold%0d: got valid %b data %b expected 1 %b", i, bus.OutValid, bus.OutData, heldData); else passed++;
        end
        @(posedge Clock); #1;
        checks++; if (gotQ.size() !== sz) $display("FAIL bp_no_pop: got %0d expected %0d", gotQ.size(), sz); else passed++;
        bus.OutReady = 1'b1;
        wait_done(to);
        d = firstDiff();
        checks++; if (to || d != -1) $display("FAIL bp_data: first bad index %0d expected -1", d); else passed++;
    endtask

    task automatic test_reset_mid();
        bit to;
        logic [5:0] outs;
        fill_mem(2);
        start_run(6'd33, 6'd12);
        repeat (45) @(posedge Clock);
        #2 Reset = 1'b0;
        #1;
        outs = {bus.RdEn, bus.OutValid, bus.OutData, bus.Busy, bus.Done, 1'b0};
        checks++; if (outs !== 6'd0 || bus.RdAddr !== 6'd0)
            $display("FAIL rst_mid_outs: got %b addr %0d expected 000000 addr 0", outs, bus.RdAddr); else passed++;
        @(posedge Clock); #1;
        Reset = 1'b1;
        @(posedge Clock); #1;
        fill_mem(0);
        start_run(6'd0, 6'd5);
        wait_done(to);
        checks++; if (to || gotQ.size() !== 32 || gotQ.sum() !== 0)
            $display("FAIL rst_mid_rerun: got %0d bits with %0d ones expected 32 with 0", gotQ.size(), gotQ.sum()); else passed++;
    endtask

    task automatic test_ignored_start();
        bit to;
        int d;
        fill_mem(2);
        start_run(6'd21, 6'd60);
        repeat (10) @(posedge Clock); #1;
        bus.InitState = 6'd63; bus.StartCol = 6'd7; bus.Start = 1'b1;
        @(posedge Clock); #1;
        bus.Start = 1'b0;
        for (int i = 0; i < 200 && !seenValid; i++) begin
            @(posedge Clock); #1;
        end
        bus.Start = 1'b1;
        @(posedge Clock); #1;
        bus.Start = 1'b0;
        wait_done(to);
        checks++; if (addrQ.size() !== 64) $display("FAIL ign_reads: got %0d expected 64", addrQ.size()); else passed++;
        d = firstDiff();
        checks++; if (to || d != -1) $display("FAIL ign_data: first bad index %0d expected -1", d); else passed++;
        repeat (3) @(posedge Clock); #1;
        checks++; if (bus.Busy !== 1'b0 || addrQ.size() !== 64) $display("FAIL ign_idle: got busy %b reads %0d expected 0 64", bus.Busy, addrQ.size()); else passed++;
    endtask

    task automatic test_back_to_back();
        bit to;
        int d;
        fill_mem(2);
        start_run(6'd50, 6'd0);
        wait_done(to);
        d = firstDiff();
        checks++; if (to || d != -1) $display("FAIL b2b_run1: first bad index %0d expected -1", d); else passed++;
        start_run(6'd7, 6'd31);
        wait_done(to);
        checks++; if (firstValidCyc - startCyc !== 66) $display("FAIL b2b_latency: got %0d expected 66", firstValidCyc - startCyc); else passed++;
        d = firstDiff();
        checks++; if (to || d != -1) $display("FAIL b2b_run2: first bad index %0d expected -1", d); else passed++;
    endtask

    initial begin
        bus.Start     = 1'b0;
        bus.InitState = '0;
        bus.StartCol  = '0;
        bus.OutReady  = 1'b1;
        fill_mem(0);
        test_reset();
        test_all_zero();
        test_all_ones();
        test_addr_seq();
        test_backpressure();
        test_reset_mid();
        test_ignored_start();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/traceback_engine.md
TRACEBACK_ENGINE -- requirements
Module: traceback_engine

Interface
REQ-001 The module SHALL have parameter WD_STATE, default 6: state register width (constraint length minus 1); trellis has 2^WD_STATE states.
REQ-002 The module SHALL have parameter WD_COL, default 6: survivor-memory column address width; columns wrap modulo 2^WD_COL.
REQ-003 The module SHALL have parameter TB_DEPTH, default 32: traceback steps discarded before decoding (at least 1).
REQ-004 The module SHALL have parameter DEC_LEN, default 32: decoded bits produced per run (at least 1).
REQ-005 The module SHALL have port Clock  input  1  single clock; all state changes on its rising edge.
REQ-006 The module SHALL have port Reset  input  1  asynchronous, active-low reset.
REQ-007 The module SHALL have port Start  input  1  request a traceback run, sampled only in IDLE.
REQ-008 The module SHALL have port InitState  input  WD_STATE  start state of the run, latched with Start.
REQ-009 The module SHALL have port StartCol  input  WD_COL  newest survivor column, latched with Start.
REQ-010 The module SHALL have port RdEn  output  1  survivor-memory read enable.
REQ-011 The module SHALL have port RdAddr  output  WD_COL  survivor-memory column address.
REQ-012 The module SHALL have port RdData  input  2^WD_STATE  survivor word, valid exactly 1 cycle after RdEn.
REQ-013 The module SHALL have port OutValid  output  1  OutData valid.
REQ-014 The module SHALL have port OutReady  input  1  consumer accepts OutData.
REQ-015 The module SHALL have port OutData  output  1  decoded bit.
REQ-016 The module SHALL have port Busy  output  1  high in every state except IDLE.
REQ-017 The module SHALL have port Done  output  1  one-cycle pulse when the last bit of a run is accepted.

Function
REQ-018 The FSM SHALL have states IDLE, TRACE, DECODE, DRAIN; IDLE->TRACE on Start, TRACE->DECODE after TB_DEPTH steps applied, DECODE->DRAIN after DEC_LEN further steps applied, DRAIN->IDLE when the last buffered bit is accepted.
REQ-019 Start in IDLE SHALL latch InitState into the state register and StartCol into the column counter; Start outside IDLE SHALL be ignored.
REQ-020 In TRACE/DECODE, RdEn SHALL be 1 and RdAddr SHALL equal the column counter, which decrements by 1 per cycle, wrapping 0 -> 2^WD_COL-1.
REQ-021 The first read SHALL issue in the cycle after Start is sampled; one step SHALL be applied per cycle from the following cycle, pipelined without bubbles.
REQ-022 A step SHALL compute bit = state[WD_STATE-1], then state <= {state[WD_STATE-2:0], RdData[state]}.
REQ-023 RdEn SHALL drop once TB_DEPTH+DEC_LEN reads are issued; no extra read SHALL occur.
REQ-024 Bits from steps TB_DEPTH+1..TB_DEPTH+DEC_LEN SHALL be pushed into a DEC_LEN-deep LIFO; TRACE-step bits SHALL be discarded.
REQ-025 In DRAIN, OutValid SHALL be 1 and OutData SHALL be the LIFO top (last pushed = oldest in time); a pop SHALL occur only when OutValid and OutReady are both 1.
REQ-026 With OutReady low, OutData and OutValid SHALL hold unchanged.
REQ-027 Done SHALL pulse in the cycle the DEC_LEN-th bit is accepted; the FSM SHALL be in IDLE the next cycle and SHALL accept Start in that cycle.
REQ-028 Latency, Start sampled to first OutValid, SHALL be TB_DEPTH+DEC_LEN+2 cycles.

Reset
REQ-029 Reset low SHALL asynchronously force IDLE, state register 0, column counter 0, LIFO empty, RdEn 0, RdAddr 0, OutValid 0, OutData 0, Busy 0, Done 0, in any state including mid-run.
REQ-030 After Reset release, the first Start SHALL begin a clean run with no residue from an aborted run.

Structure
REQ-031 WD_STATE, WD_COL, TB_DEPTH and DEC_LEN defaults and the FSM state encodings SHALL reside in the shared parameter package.
REQ-032 The LIFO SHALL be a sub-module named bit_lifo (parameter DEPTH; push, pop, data, empty).

Verification
REQ-033 All-zero RdData, InitState=0, defaults: Start -> 32 OutData=0, Done once, Busy low after.
REQ-034 All-ones RdData, InitState=0: Start -> 32 OutData=1 (state saturates to 63 within TRACE).
REQ-035 StartCol=3: RdAddr sequence 3,2,1,0,63,62,... for 64 cycles, then RdEn=0.
REQ-036 OutReady low 5 cycles mid-DRAIN -> OutData/OutValid held; 32 bits still delivered, order unchanged.
REQ-037 Reset pulsed mid-DECODE -> all outputs 0 immediately; a new Start with all-zero RdData yields 32 zeros.
REQ-038 Start pulsed during TRACE and DRAIN -> ignored; read count stays 64 and output count stays 32.
